// File: rtl/smem_pkg.sv
// Shared definitions for the SMEM extend datapath: response bundle layout and default widths.
package smem_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_TAG_W     = 7;
  localparam int unsigned CNT_A_W       = 32;
  localparam int unsigned CNT_B_W       = 64;
  localparam int unsigned RESP_BUNDLE_W = 768;

  // Bit offsets of each count field inside the response bundle (cnt_a0 at bit 0).
  localparam int unsigned CNT_A0_OFF  = 0;
  localparam int unsigned CNT_A1_OFF  = 32;
  localparam int unsigned CNT_A2_OFF  = 64;
  localparam int unsigned CNT_A3_OFF  = 96;
  localparam int unsigned CNT_B0_OFF  = 128;
  localparam int unsigned CNT_B1_OFF  = 192;
  localparam int unsigned CNT_B2_OFF  = 256;
  localparam int unsigned CNT_B3_OFF  = 320;
  localparam int unsigned CNTL_A0_OFF = 384;
  localparam int unsigned CNTL_A1_OFF = 416;
  localparam int unsigned CNTL_A2_OFF = 448;
  localparam int unsigned CNTL_A3_OFF = 480;
  localparam int unsigned CNTL_B0_OFF = 512;
  localparam int unsigned CNTL_B1_OFF = 576;
  localparam int unsigned CNTL_B2_OFF = 640;
  localparam int unsigned CNTL_B3_OFF = 704;

  // Packed MSB-first, so cnt_a[0] lands at bit 0 to match the offsets above.
  typedef struct packed {
    logic [3:0][CNT_B_W-1:0] cntl_b;
    logic [3:0][CNT_A_W-1:0] cntl_a;
    logic [3:0][CNT_B_W-1:0] cnt_b;
    logic [3:0][CNT_A_W-1:0] cnt_a;
  } resp_bundle;

endpackage

// File: rtl/occ_slot_ram.sv
// Per-slot {tag, response} storage: one write port, one read port with a registered address.
module occ_slot_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 775
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0]         r_mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] r_raddr;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_raddr <= '0;
    end else begin
      r_raddr <= i_raddr;
    end
  end

  // A write at an edge is visible through the read port in the following cycle.
  assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/bwt_occ_req_tracker.sv
// Tracks outstanding BWT occurrence lookups to DRAM and returns responses in issue order.
module bwt_occ_req_tracker
  import smem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned RESP_W  = RESP_BUNDLE_W,
  parameter int unsigned REORDER = 0
) (
  input  logic                     Clk_32UI,
  input  logic                     reset_BWT_extend,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [ADDR_W-1:0]        req_addr_k,
  input  logic [ADDR_W-1:0]        req_addr_l,
  output logic                     DRAM_valid,
  input  logic                     DRAM_ready,
  output logic [ADDR_W-1:0]        addr_k,
  output logic [ADDR_W-1:0]        addr_l,
  output logic [$clog2(DEPTH)-1:0] DRAM_id,
  input  logic                     DRAM_get,
  input  logic [$clog2(DEPTH)-1:0] DRAM_rsp_id,
  input  logic [RESP_W-1:0]        DRAM_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [RESP_W-1:0]        rsp_data,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexpected
);

  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam int unsigned       RAM_W      = TAG_W + RESP_W;
  localparam logic [PTR_W:0]    LP_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    LP_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  LP_PTR_ONE = PTR_W'(1);

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  r_done;
  logic [TAG_W-1:0]  r_tag [DEPTH];
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W:0]    r_outstanding;
  logic              r_rst_done;

  logic              r_dram_valid;
  logic [ADDR_W-1:0] r_addr_k;
  logic [ADDR_W-1:0] r_addr_l;
  logic [PTR_W-1:0]  r_dram_id;

  logic              r_rsp_valid;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic [RESP_W-1:0] r_rsp_data;
  logic              r_err;

  logic              w_req_ready;
  logic              w_accept;
  logic [PTR_W-1:0]  w_rsp_slot;
  logic              w_rsp_ok;
  logic              w_rsp_bad;
  logic              w_release;
  logic [PTR_W-1:0]  w_head_nxt;
  logic [DEPTH-1:0]  w_pending_nxt;
  logic [DEPTH-1:0]  w_done_nxt;
  logic [RAM_W-1:0]  w_ram_rdata;

  // r_rst_done keeps req_ready low while reset is held and for the first edge after it.
  always_comb begin
    w_req_ready = r_rst_done && (r_outstanding < LP_FULL) && (!r_dram_valid || DRAM_ready);
    w_accept    = req_valid && w_req_ready;
    if (REORDER != 0) begin
      w_rsp_slot = DRAM_rsp_id;
    end else begin
      w_rsp_slot = r_wr;
    end
    w_rsp_ok   = DRAM_get && r_pending[w_rsp_slot] && !r_done[w_rsp_slot];
    w_rsp_bad  = DRAM_get && !(r_pending[w_rsp_slot] && !r_done[w_rsp_slot]);
    w_release  = r_done[r_head] && (!r_rsp_valid || rsp_ready);
    w_head_nxt = w_release ? (r_head + LP_PTR_ONE) : r_head;
  end

  // The released, accepted and responding slots are always distinct, so update order is free.
  always_comb begin
    w_pending_nxt = r_pending;
    w_done_nxt    = r_done;
    if (w_release) begin
      w_pending_nxt[r_head] = 1'b0;
      w_done_nxt[r_head]    = 1'b0;
    end
    if (w_accept) begin
      w_pending_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]    = 1'b0;
    end
    if (w_rsp_ok) begin
      w_done_nxt[w_rsp_slot] = 1'b1;
    end
  end

  always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
    if (!reset_BWT_extend) begin
      r_pending     <= '0;
      r_done        <= '0;
      r_tag         <= '{default: '0};
      r_tail        <= '0;
      r_head        <= '0;
      r_wr          <= '0;
      r_outstanding <= '0;
      r_rst_done    <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_done     <= w_done_nxt;
      r_head     <= w_head_nxt;
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_tag[r_tail] <= req_tag;
        r_tail        <= r_tail + LP_PTR_ONE;
      end
      if (w_rsp_ok && (REORDER == 0)) begin
        r_wr <= r_wr + LP_PTR_ONE;
      end
      case ({w_accept, w_release})
        2'b10:   r_outstanding <= r_outstanding + LP_CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - LP_CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
    if (!reset_BWT_extend) begin
      r_dram_valid <= 1'b0;
      r_addr_k     <= '0;
      r_addr_l     <= '0;
      r_dram_id    <= '0;
    end else if (w_accept) begin
      r_dram_valid <= 1'b1;
      r_addr_k     <= req_addr_k;
      r_addr_l     <= req_addr_l;
      r_dram_id    <= r_tail;
    end else if (DRAM_ready) begin
      r_dram_valid <= 1'b0;
    end
  end

  // The output register decouples rsp_data from the slot, which may be reused during a stall.
  always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
    if (!reset_BWT_extend) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
    end else if (w_release) begin
      r_rsp_valid <= 1'b1;
      r_rsp_tag   <= w_ram_rdata[RAM_W-1 -: TAG_W];
      r_rsp_data  <= w_ram_rdata[RESP_W-1:0];
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
    if (!reset_BWT_extend) begin
      r_err <= 1'b0;
    end else if (w_rsp_bad) begin
      r_err <= 1'b1;
    end
  end

  // Read address tracks the next head so the head slot is readable in the release cycle.
  occ_slot_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W)
  ) u_slot_ram (
    .i_clk   (Clk_32UI),
    .i_rst_n (reset_BWT_extend),
    .i_we    (w_rsp_ok),
    .i_waddr (w_rsp_slot),
    .i_wdata ({r_tag[w_rsp_slot], DRAM_data}),
    .i_raddr (w_head_nxt),
    .o_rdata (w_ram_rdata)
  );

  assign req_ready      = w_req_ready;
  assign DRAM_valid     = r_dram_valid;
  assign addr_k         = r_addr_k;
  assign addr_l         = r_addr_l;
  assign DRAM_id        = r_dram_id;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_tag        = r_rsp_tag;
  assign rsp_data       = r_rsp_data;
  assign outstanding    = r_outstanding;
  assign err_unexpected = r_err;

endmodule

// File: doc/bwt_occ_req_tracker.md
# bwt_occ_req_tracker

Parametrised tracker for BWT occurrence lookups, sitting between the SMEM extend pipeline and the DRAM port. It accepts (k,l) lookup requests tagged with a read index and forwards them to DRAM. It buffers up to DEPTH outstanding lookups and absorbs DRAM responses that arrive while the pipeline is stalled. Responses are returned to the pipeline strictly in issue order, in both in-order and out-of-order DRAM modes.

## Interface

Parameters:
- ADDR_W, 32, width of addr_k/addr_l
- TAG_W, 7, read-index tag width (matches curr memory address width)
- DEPTH, 16, outstanding slots; power of two, ≥2
- RESP_W, 768, response bundle: cnt_a0..3 (4×32), cnt_b0..3 (4×64), cntl_a0..3 (4×32), cntl_b0..3 (4×64)
- REORDER, 0, 0 = DRAM returns in issue order and DRAM_rsp_id is ignored; 1 = DRAM returns out of order and DRAM_rsp_id selects the slot

Ports (PTR_W = log2(DEPTH)):
- Clk_32UI  in  1  sole clock, rising edge
- reset_BWT_extend  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_tag  in  TAG_W  read index
- req_addr_k, req_addr_l  in  ADDR_W  occurrence addresses
- DRAM_valid  out  1  DRAM request valid, held until DRAM_ready
- DRAM_ready  in  1  DRAM accepts request
- addr_k, addr_l  out  ADDR_W  DRAM request addresses
- DRAM_id  out  PTR_W  slot index issued with the request
- DRAM_get  in  1  response strobe, one cycle per response, no backpressure
- DRAM_rsp_id  in  PTR_W  slot of the response (used when REORDER=1)
- DRAM_data  in  RESP_W  response bundle
- rsp_valid  out  1  response to pipeline
- rsp_ready  in  1  pipeline not stalled
- rsp_tag  out  TAG_W  tag of the returned response
- rsp_data  out  RESP_W  bundle of the returned response
- outstanding  out  PTR_W+1  allocated slots
- err_unexpected  out  1  sticky: response arrived for a slot that is not pending

## Operation

- Slot array of DEPTH entries, each {tag, pending, done, data}. Pointers: alloc (tail), head (release), wr (in-order response write). All pointers are PTR_W bits wide and wrap modulo DEPTH.
- Accept: the block allocates the tail slot with pending=1 and stores the tag. It loads the DRAM request register {addr_k, addr_l, DRAM_id=tail} and sets DRAM_valid.
- req_ready = (outstanding < DEPTH) && (!DRAM_valid || DRAM_ready).
- Response: the slot is `wr` (REORDER=0, then wr increments) or `DRAM_rsp_id` (REORDER=1). If that slot is pending and not done, the block writes data and sets done. Otherwise the response is dropped, err_unexpected sets, and wr does not advance.
- Release: if head is done and (!rsp_valid || rsp_ready), the block loads {rsp_tag, rsp_data} from head, sets rsp_valid, clears pending/done, and increments head. If rsp_valid && rsp_ready with no release, rsp_valid clears.
- outstanding: +1 on accept, −1 on release; unchanged when both happen in the same cycle.
- err_unexpected clears only on reset.

## Timing

- Reset values: every output is 0 (req_ready becomes 1 on the first cycle after deassertion). All slots are invalid and all pointers are 0.
- Accept at edge t → DRAM_valid=1 from t+1. Back-to-back issue runs at 1/cycle while DRAM_ready=1.
- DRAM_get in cycle t → captured at edge t. Earliest rsp_valid is in cycle t+2, so minimum response latency is 2 cycles.
- Sustained throughput is 1 response/cycle with rsp_ready=1.
- Full (outstanding==DEPTH): req_ready=0. A release in the same cycle does not raise req_ready until the next cycle.
- Stall: while rsp_ready=0, rsp outputs hold stable and responses keep accumulating in slots. No DRAM_get is lost.
- Simultaneous accept, DRAM_get and release in one cycle are all legal.
- A reset asserted mid-operation drops all in-flight state immediately. DRAM responses arriving after reset set err_unexpected.

## Structure

- The shared package smem_pkg holds:
  - field offset constants for the 16 cnt/cntl fields within RESP_W
  - the resp_bundle typedef
  - the default ADDR_W/TAG_W constants
- One sub-module, occ_slot_ram: DEPTH×(TAG_W+RESP_W) storage with one write port and one registered-address read port. Pending/done flags stay in flops in the top-level module.

## Test plan

- Basic, REORDER=0, DEPTH=16: 3 requests with tags 0,1,2 and addr_k=0x6bfa2ffe, addr_l=0x105c96189[31:0]. Three consecutive DRAM_get with cnt_a0=0, 0x4fd3521c, 0x4fd3521c → rsp_tag 0,1,2 in order with the matching data; first rsp_valid 2 cycles after the first DRAM_get.
- Stall absorption: rsp_ready=0 while 3 responses arrive, held 10 cycles → rsp_valid=1 with tag 0 held stable. After rsp_ready=1, tags 0,1,2 on 3 consecutive cycles; outstanding goes 3→0.
- Full, DEPTH=4: 5 requests offered with no responses → 4 accepted, req_ready=0, outstanding=4. One response released → the fifth request is accepted the cycle after.
- Reorder, REORDER=1: responses for slots 2,0,1 → output order is still tags 0,1,2. rsp_valid only after slot 0's response.
- Error: DRAM_get with DRAM_rsp_id=5 when only slots 0–1 are pending → err_unexpected=1 sticky and outstanding unchanged. Reset clears it.
- DRAM backpressure plus reset mid-operation: with DRAM_ready=0, a second request is refused and DRAM_valid/addr_k stay stable. Asserting reset → all outputs 0 within the same cycle.
